// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared UART definitions: receiver state encoding, frame width and
// baud-divider helper used by both the receiver and the transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

    // Clocks per bit period, truncated toward zero.
    function automatic int clks_per_bit(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
`timescale 1ns/1ps
// Two-flop synchroniser for a single asynchronous input.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic n_reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; both preset to the line's idle level.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// 8N1 UART receiver: mid-bit sampling, LSB-first assembly, one-entry
// holding register, framing-error and overrun pulses.
//
// Handshake: rx_valid means rx_data holds an unconsumed byte; a transfer
// happens on every rising clk edge where rx_valid and rx_ready are both 1.
// rx_data never changes while rx_valid=1 except on a transfer edge, and
// rx_valid does not depend combinationally on rx_ready.
module uart_rx
    import uart_pkg::*;
#(
    parameter int UART_CLOCK_HZ = 20_000_000,
    parameter int UART_BAUD     = 115200
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic                      uart_rx_pin,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam int CLKS_PER_BIT = clks_per_bit(UART_CLOCK_HZ, UART_BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end

    logic                      rxs;
    uart_rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                      byte_done;
    logic                      stop_bad;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .d       (uart_rx_pin),
        .q       (rxs)
    );

    // Frame FSM registers: state, shared bit counter, bit index, shift register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    // Frame FSM next state; STOP leaves at mid-stop-bit so a back-to-back
    // start edge is never missed.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rxs, shreg_q[UART_DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) state_d = STOP;
                    else                   idx_d   = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        stop_bad  = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                // A held-low (break) line must not decode as repeated 0x00.
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register and one-cycle error pulses.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (byte_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg_q;
                    rx_valid <= 1'b1;
                end else begin
                    overrun  <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx: table-driven frames, hand-written
// corner sequences and randomized frames against a frame-level model.
module tb_uart_rx;

    localparam int CLK_NS = 50;     // 20 MHz
    localparam int BIT_NS = 8680;   // ~115200 baud

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       n_reset;
    logic       uart_rx_pin;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    always #(CLK_NS/2) clk = ~clk;

    uart_rx #(
        .UART_CLOCK_HZ (20_000_000),
        .UART_BAUD     (115200)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .uart_rx_pin (uart_rx_pin),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         beat_cnt = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_ferr  = 1'b0;
    logic       prev_ovr   = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (n_reset) begin
            if (rx_valid && rx_ready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no byte at %0t", rx_data, $time);
                end else begin
                    check("rx_data", int'(rx_data), int'(exp_q.pop_front()));
                end
            end
            if (frame_err) begin
                ferr_cnt++;
                check("frame_err_width", int'(prev_ferr), 0);
                check("ferr_ovr_exclusive", int'(overrun), 0);
            end
            if (overrun) begin
                ovr_cnt++;
                check("overrun_width", int'(prev_ovr), 0);
            end
            if (prev_valid && !prev_ready && rx_valid)
                check("rx_data_stable", int'(rx_data), int'(prev_data));
        end
        prev_valid = rx_valid;
        prev_ready = rx_ready;
        prev_ferr  = frame_err;
        prev_ovr   = overrun;
        prev_data  = rx_data;
    end

    // ---------------- driver tasks ----------------
    // Start bit, 8 data bits LSB first, then the given stop level (left on the line).
    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rx_pin = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            uart_rx_pin = b[i];
            #(BIT_NS);
        end
        uart_rx_pin = stop;
        #(BIT_NS);
    endtask

    task automatic line_idle(input int bits);
        uart_rx_pin = 1'b1;
        #(bits * BIT_NS);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 rx_ready = r;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         idle_bits;
        int         exp_beats;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    int b0, f0, o0;

    initial begin
        vecs[0] = '{data: 8'h48, stop: 1'b1, idle_bits: 2, exp_beats: 1, exp_ferr: 0};
        vecs[1] = '{data: 8'hFF, stop: 1'b1, idle_bits: 1, exp_beats: 1, exp_ferr: 0};
        vecs[2] = '{data: 8'h00, stop: 1'b1, idle_bits: 1, exp_beats: 1, exp_ferr: 0};
        vecs[3] = '{data: 8'h81, stop: 1'b0, idle_bits: 2, exp_beats: 0, exp_ferr: 1};
        vecs[4] = '{data: 8'hC3, stop: 1'b1, idle_bits: 2, exp_beats: 1, exp_ferr: 0};
        vecs[5] = '{data: 8'h01, stop: 1'b0, idle_bits: 1, exp_beats: 0, exp_ferr: 1};

        // Reset state
        n_reset     = 1'b0;
        uart_rx_pin = 1'b1;
        rx_ready    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_overrun", int'(overrun), 0);
        @(posedge clk);
        #1 n_reset = 1'b1;
        line_idle(1);

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            b0 = beat_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
            if (vecs[v].exp_beats != 0) exp_q.push_back(vecs[v].data);
            send_frame(vecs[v].data, vecs[v].stop);
            line_idle(vecs[v].idle_bits);
            check("vec_beats", beat_cnt - b0, vecs[v].exp_beats);
            check("vec_frame_err", ferr_cnt - f0, vecs[v].exp_ferr);
            check("vec_overrun", ovr_cnt - o0, 0);
        end

        // Back-to-back 0x55, 0xAA
        b0 = beat_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        line_idle(2);
        check("b2b_beats", beat_cnt - b0, 2);
        check("b2b_overrun", ovr_cnt - o0, 0);

        // 40-clock glitch rejected, then 0x3C
        b0 = beat_cnt; f0 = ferr_cnt;
        uart_rx_pin = 1'b0;
        #(40 * CLK_NS);
        line_idle(2);
        check("glitch_beats", beat_cnt - b0, 0);
        check("glitch_frame_err", ferr_cnt - f0, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        line_idle(2);
        check("after_glitch_beats", beat_cnt - b0, 1);

        // Bad stop bit followed by a held-low break, then 0x7E
        b0 = beat_cnt; f0 = ferr_cnt;
        send_frame(8'h00, 1'b0);
        #(3 * BIT_NS);
        line_idle(2);
        check("break_frame_err", ferr_cnt - f0, 1);
        check("break_beats", beat_cnt - b0, 0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        line_idle(2);
        check("after_break_beats", beat_cnt - b0, 1);

        // Overrun: consumer stalled for two frames
        o0 = ovr_cnt;
        set_ready(1'b0);
        exp_q.push_back(8'h31);
        send_frame(8'h31, 1'b1);
        send_frame(8'h32, 1'b1);
        line_idle(1);
        @(negedge clk);
        check("ovr_rx_valid", int'(rx_valid), 1);
        check("ovr_rx_data", int'(rx_data), 8'h31);
        check("ovr_pulses", ovr_cnt - o0, 1);
        set_ready(1'b1);
        repeat (2) @(negedge clk);
        check("ovr_drain_valid", int'(rx_valid), 0);
        check("ovr_queue_empty", exp_q.size(), 0);

        // Reset during data bit 4 of 0xA5
        b0 = beat_cnt;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                #(BIT_NS * 5 + BIT_NS / 2);
                n_reset = 1'b0;
                #1;
                check("midreset_rx_data", int'(rx_data), 0);
                check("midreset_rx_valid", int'(rx_valid), 0);
                check("midreset_frame_err", int'(frame_err), 0);
                check("midreset_overrun", int'(overrun), 0);
            end
        join
        #(BIT_NS);
        n_reset = 1'b1;
        line_idle(2);
        check("midreset_no_partial", beat_cnt - b0, 0);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        line_idle(2);
        check("midreset_resend", beat_cnt - b0, 1);

        // "Hello" as a continuous transmitter stream
        b0 = beat_cnt;
        begin
            logic [7:0] hello[5];
            hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
            foreach (hello[k]) exp_q.push_back(hello[k]);
            foreach (hello[k]) send_frame(hello[k], 1'b1);
        end
        line_idle(2);
        check("hello_beats", beat_cnt - b0, 5);

        // Randomized frames against a frame-level model
        begin
            int exp_b, exp_f;
            logic [7:0] d;
            logic       good;
            int         gap;
            b0 = beat_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
            exp_b = 0; exp_f = 0;
            for (int n = 0; n < 12; n++) begin
                d    = 8'($urandom_range(0, 255));
                good = ($urandom_range(0, 5) != 0);
                gap  = good ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
                if (good) begin
                    exp_q.push_back(d);
                    exp_b++;
                end else begin
                    exp_f++;
                end
                send_frame(d, good);
                if (gap > 0) line_idle(gap);
            end
            line_idle(2);
            check("rand_beats", beat_cnt - b0, exp_b);
            check("rand_frame_err", ferr_cnt - f0, exp_f);
            check("rand_overrun", ovr_cnt - o0, 0);
        end

        repeat (4) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver for the SoC. It pairs with the SoC's existing UART transmitter and shares its clock/baud parameterisation.
- Samples the asynchronous `uart_rx_pin` at mid-bit.
- Assembles bytes LSB-first.
- Delivers each byte through a one-entry valid/ready holding register to the bus-side UART peripheral.
- Flags framing errors and overruns as one-cycle pulses.

Parameters:
- UART_CLOCK_HZ, 20_000_000, frequency of `clk` in Hz.
- UART_BAUD, 115200, line bit rate.
- CLKS_PER_BIT, UART_CLOCK_HZ/UART_BAUD (integer division, derived localparam), clocks per bit. 173 at the defaults.

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- uart_rx_pin  in  1  serial line, idle high, asynchronous to clk
- rx_data  out  8  received byte; stable while rx_valid=1
- rx_valid  out  1  holding register full
- rx_ready  in  1  consumer accepts rx_data when rx_valid&rx_ready
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: completed byte dropped because holding register full

Behaviour:
- Interface: one clock `clk`; reset `n_reset` is asynchronous, active-low.
- Reset values:
  - rx_data=0x00, rx_valid=0, frame_err=0, overrun=0.
  - Synchroniser flops=1; state=IDLE; counters=0.
  - Reset asserted mid-frame aborts the frame immediately; no partial byte is delivered.
- Elaboration error if CLKS_PER_BIT < 4.
- Synchroniser: 2 flops on uart_rx_pin. All logic uses the synchronised value `rxs`, which lags the line by 2 cycles.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. Shared bit counter `cnt` is 0..CLKS_PER_BIT-1. Bit index `idx` is 0..7.
- IDLE:
  - rxs=0 -> START, cnt=0.
- START:
  - When cnt==CLKS_PER_BIT/2-1, sample rxs.
  - rxs=0 -> DATA, cnt=0, idx=0.
  - rxs=1 -> IDLE (glitch rejected; no flag).
- DATA:
  - When cnt==CLKS_PER_BIT-1, sample rxs: shift register shifts right with the sample entering bit 7 (LSB-first line order); cnt=0.
  - idx==7 -> STOP; else idx+1.
- STOP:
  - When cnt==CLKS_PER_BIT-1, sample rxs.
  - 1 -> byte complete, IDLE.
  - 0 -> frame_err pulse next cycle, byte discarded, WAIT_HIGH.
- WAIT_HIGH:
  - rxs=1 -> IDLE. Prevents a break/low line from being decoded as repeated 0x00 frames.
- Back-to-back frames: STOP returns to IDLE at mid-stop-bit, so the next start edge is caught with no lost bits.
- Holding register (byte complete in cycle T):
  - If rx_valid=0, or rx_valid&rx_ready in cycle T: rx_data<=byte, rx_valid=1 in T+1.
  - Otherwise: old rx_data retained, new byte dropped, overrun=1 in T+1 only.
- Handshake:
  - rx_valid&rx_ready with no completion in the same cycle -> rx_valid=0 next cycle.
  - rx_data does not change while rx_valid=1 unless that same cycle is a handshake.
- Latency: rx_valid rises 1 clk after the stop-bit sample, which is about 9.5 bit times + 3 clk after the line's start edge.
- frame_err and overrun never assert together; each is exactly 1 cycle wide.

Decomposition:
- Package `uart_pkg`, shared with the UART transmitter:
  - `uart_rx_state_t` enum.
  - `UART_DATA_BITS=8`.
  - Function `clks_per_bit(clock_hz, baud)`.
- One sub-module, `uart_sync2`: 2-flop synchroniser with reset value parameter RESET_VAL=1. No other sub-modules.

Test Plan:
Defaults (173 clk/bit); bench drives the line at 8680 ns/bit.
- Send 0x48 with rx_ready=1 -> single rx_valid beat, rx_data=0x48, frame_err=0, overrun=0.
- Send 0x55 then 0xAA back-to-back (stop bit 1 bit long), rx_ready=1 -> two beats in order 0x55, 0xAA; no overrun.
- Drive line low for 40 clk then high -> no rx_valid, no frame_err; a following 0x3C is received correctly.
- Send 0x00 with stop bit low, then hold line low 3 bit times -> exactly one frame_err pulse, no rx_valid; after line high, 0x7E is received.
- rx_ready=0; send 0x31 then 0x32 -> rx_data stays 0x31, one overrun pulse at 0x32 stop sample; then rx_ready=1 -> 0x31 consumed, rx_valid=0.
- Assert n_reset during data bit 4 of 0xA5 -> outputs reset immediately; release, resend 0xA5 -> received 0xA5. Loopback from SoC uart_tx "Hello" -> bytes 48 65 6C 6C 6F.
